// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle execute controller sitting between issue logic,
// a synchronous-read register file and a combinational ALU.
// Sequence per instruction: RD (address the RF), EX (drive the ALU and capture
// its result), WB (write back to the RF and commit the zero flag).
module alu_exec_ctrl #(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_instr_valid,
  output logic             o_instr_ready,
  input  logic [15:0]      i_instr,
  output logic [ASIZE-1:0] o_rf_raddr1,
  output logic [ASIZE-1:0] o_rf_raddr2,
  input  logic [DSIZE-1:0] i_rf_rdata1,
  input  logic [DSIZE-1:0] i_rf_rdata2,
  output logic [DSIZE-1:0] o_alu_a,
  output logic [DSIZE-1:0] o_alu_b,
  output logic [2:0]       o_alu_op,
  input  logic [DSIZE-1:0] i_alu_out,
  input  logic             i_alu_zero,
  output logic             o_rf_we,
  output logic [ASIZE-1:0] o_rf_waddr,
  output logic [DSIZE-1:0] o_rf_wdata,
  output logic             o_zero_flag,
  output logic             o_illegal
);

  localparam int unsigned IMM_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_EX   = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_COM  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [11:0]      r_instr;        // rd/rs/rt fields of the accepted instruction
  logic [2:0]       r_op;
  logic [DSIZE-1:0] r_result;
  logic             r_zero;
  logic             r_zero_flag;
  logic             r_illegal;

  logic             w_ready;
  logic             w_xfer;
  logic             w_legal;
  logic [2:0]       w_op_map;
  logic [DSIZE-1:0] w_imm_sext;

  // Handshake: accept in IDLE and WB; held low while in reset
  assign w_ready = rst_n & ((r_state == ST_IDLE) | (r_state == ST_WB));
  assign w_xfer  = i_instr_valid & w_ready;
  assign w_legal = (i_instr[15:12] < 4'd7);

  // Opcode to ALU operation mapping
  always_comb begin
    w_op_map = OP_ADD;
    case (i_instr[15:12])
      4'd0:    w_op_map = OP_ADD;
      4'd1:    w_op_map = OP_SUB;
      4'd2:    w_op_map = OP_AND;
      4'd3:    w_op_map = OP_XOR;
      4'd4:    w_op_map = OP_COM;
      4'd5:    w_op_map = OP_MUL;
      4'd6:    w_op_map = OP_ADDI;
      default: w_op_map = OP_ADD;
    endcase
  end

  assign w_imm_sext = {{(DSIZE-IMM_W){r_instr[3]}}, r_instr[3:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; illegal transfers never leave IDLE and do not cut WB short
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = (w_xfer && w_legal) ? ST_RD : ST_IDLE;
      ST_RD:   w_state_nxt = ST_EX;
      ST_EX:   w_state_nxt = ST_WB;
      ST_WB:   w_state_nxt = (w_xfer && w_legal) ? ST_RD : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Instruction latch, result capture, zero flag commit and illegal pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr     <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_zero_flag <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= w_xfer & ~w_legal;
      if (w_xfer && w_legal) begin
        r_instr <= i_instr[11:0];
        r_op    <= w_op_map;
      end
      if (r_state == ST_EX) begin
        r_result <= i_alu_out;
        r_zero   <= i_alu_zero;
      end
      if (r_state == ST_WB) r_zero_flag <= r_zero;
    end
  end

  // Per-state decode of RF and ALU side outputs; all zero in IDLE and reset
  always_comb begin
    o_rf_raddr1 = '0;
    o_rf_raddr2 = '0;
    o_alu_a     = '0;
    o_alu_b     = '0;
    o_alu_op    = '0;
    o_rf_we     = 1'b0;
    o_rf_waddr  = '0;
    o_rf_wdata  = '0;
    if (r_state != ST_IDLE) begin
      o_rf_raddr1 = ASIZE'(r_instr[7:4]);
      o_rf_raddr2 = ASIZE'(r_instr[3:0]);
    end
    if (r_state == ST_EX) begin
      o_alu_a  = i_rf_rdata1;
      o_alu_b  = (r_op == OP_ADDI) ? w_imm_sext : i_rf_rdata2;
      o_alu_op = r_op;
    end
    if (r_state == ST_WB) begin
      o_rf_waddr = ASIZE'(r_instr[11:8]);
      o_rf_wdata = r_result;
      o_rf_we    = (r_instr[11:8] != 4'd0);
    end
  end

  assign o_instr_ready = w_ready;
  assign o_zero_flag   = r_zero_flag;
  assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: provides a sync-read register file and an ALU,
// applies a vector table, directed multi-cycle sequences and random streams.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  raddr1, raddr2;
  logic [15:0] rdata1, rdata2;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        rf_we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        zero_flag;
  logic        illegal;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DSIZE(16), .ASIZE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_instr_valid(instr_valid), .o_instr_ready(instr_ready), .i_instr(instr),
    .o_rf_raddr1(raddr1), .o_rf_raddr2(raddr2),
    .i_rf_rdata1(rdata1), .i_rf_rdata2(rdata2),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_out(alu_out), .i_alu_zero(alu_zero),
    .o_rf_we(rf_we), .o_rf_waddr(waddr), .o_rf_wdata(wdata),
    .o_zero_flag(zero_flag), .o_illegal(illegal)
  );

  // Environment ALU
  always_comb begin
    case (alu_op)
      3'd0:    alu_out = alu_a + alu_b;
      3'd1:    alu_out = alu_a - alu_b;
      3'd2:    alu_out = alu_a & alu_b;
      3'd3:    alu_out = alu_a ^ alu_b;
      3'd4:    alu_out = {15'd0, (alu_a <= alu_b)};
      3'd5:    alu_out = alu_a * alu_b;
      3'd6:    alu_out = alu_a + alu_b;
      default: alu_out = 16'd0;
    endcase
  end
  assign alu_zero = (alu_out == 16'd0);

  // Environment register file with a bench-side preload port
  logic [15:0] rf_mem [16] = '{default: 16'd0};
  logic        tb_we = 1'b0;
  logic [3:0]  tb_waddr = 4'd0;
  logic [15:0] tb_wdata = 16'd0;
  always @(posedge clk) begin
    if (rf_we) rf_mem[waddr] <= wdata;
    if (tb_we) rf_mem[tb_waddr] <= tb_wdata;
    rdata1 <= rf_mem[raddr1];
    rdata2 <= rf_mem[raddr2];
  end

  // Write-port and illegal-pulse monitor
  typedef struct { logic [3:0] a; logic [15:0] d; int c; } wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  cyc = 0;
  int  ill_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rf_we) got_q.push_back('{a: waddr, d: wdata, c: cyc});
    if (illegal) ill_cnt = ill_cnt + 1;
  end

  int checks = 0;
  int failures = 0;
  logic [15:0] mregs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
    mregs[a] = d;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout: instr_ready stuck at 0");
    end
  endtask

  // Offer one instruction; returns at the negedge after the transfer edge
  task automatic issue(input logic [15:0] x);
    instr_valid = 1'b1; instr = x;
    wait_ready();
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Instruction-level reference: result of an instruction from operand values
  function automatic logic [15:0] ref_exec(input int op, input longint x, input longint y);
    longint r;
    case (op)
      0: r = x + y;
      1: r = x - y + 65536;
      2: r = x & y;
      3: r = x ^ y;
      4: r = (x <= y) ? 1 : 0;
      5: r = x * y;
      6: r = x + y + 65536;
      default: r = 0;
    endcase
    return 16'(r % 65536);
  endfunction

  typedef struct {
    logic [15:0] instr;
    logic [15:0] rs_val;
    logic [15:0] rt_val;
    logic [15:0] exp_wdata;
    logic        exp_we;
    logic        exp_zf;
  } vec_t;
  vec_t vecs [10];

  task automatic run_vec(input vec_t v);
    int t0;
    if (v.instr[7:4] != 4'd0) set_reg(v.instr[7:4], v.rs_val);
    if (v.instr[3:0] != 4'd0) set_reg(v.instr[3:0], v.rt_val);
    got_q.delete();
    issue(v.instr);
    t0 = cyc;
    repeat (3) @(negedge clk);
    chk($sformatf("we_count_%h", v.instr), got_q.size(), 32'(v.exp_we));
    if (got_q.size() > 0) begin
      chk($sformatf("waddr_%h", v.instr), got_q[0].a, v.instr[11:8]);
      chk($sformatf("wdata_%h", v.instr), got_q[0].d, v.exp_wdata);
      chk($sformatf("latency_%h", v.instr), got_q[0].c - t0, 2);
    end
    chk($sformatf("zero_flag_%h", v.instr), zero_flag, v.exp_zf);
    chk($sformatf("ready_after_%h", v.instr), instr_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_ill, ill0;
    logic zf_exp;
    logic [3:0] rd, rs, rt;
    int opc;
    longint x, y;
    logic [15:0] res;

    vecs[0] = '{16'h0312, 16'd5,      16'd7,      16'd12,     1'b1, 1'b0};
    vecs[1] = '{16'h1412, 16'd9,      16'd9,      16'd0,      1'b1, 1'b1};
    vecs[2] = '{16'h3512, 16'd9,      16'd9,      16'd0,      1'b1, 1'b1};
    vecs[3] = '{16'h2512, 16'd6,      16'd3,      16'd2,      1'b1, 1'b0};
    vecs[4] = '{16'h661F, 16'd4,      16'h1234,   16'd3,      1'b1, 1'b0};
    vecs[5] = '{16'h5712, 16'h0100,   16'h0100,   16'd0,      1'b1, 1'b1};
    vecs[6] = '{16'h4012, 16'd3,      16'd5,      16'd0,      1'b0, 1'b0};
    vecs[7] = '{16'h4812, 16'd5,      16'd3,      16'd0,      1'b1, 1'b1};
    vecs[8] = '{16'h1812, 16'd3,      16'd5,      16'hFFFE,   1'b1, 1'b0};
    vecs[9] = '{16'h6917, 16'hFFFC,   16'd1,      16'd3,      1'b1, 1'b0};
    for (int i = 0; i < 16; i++) mregs[i] = 16'd0;

    // Reset: every output low, including ready
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_zero_flag", zero_flag, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_raddr1", raddr1, 0);
    rst_n = 1'b1;
    #1 chk("ready_after_release", instr_ready, 1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // ADDI: operand view per phase
    set_reg(4'd1, 16'd4);
    set_reg(4'd15, 16'h1234);
    issue(16'h661F);
    chk("addi_rd_raddr1", raddr1, 1);
    chk("addi_rd_raddr2", raddr2, 15);
    chk("addi_rd_alu_b", alu_b, 0);
    chk("addi_rd_ready", instr_ready, 0);
    @(negedge clk);
    chk("addi_ex_alu_a", alu_a, 16'd4);
    chk("addi_ex_alu_b", alu_b, 16'hFFFF);
    chk("addi_ex_alu_op", alu_op, 6);
    @(negedge clk);
    chk("addi_wb_we", rf_we, 1);
    chk("addi_wb_wdata", wdata, 16'd3);
    chk("addi_wb_ready", instr_ready, 1);
    @(negedge clk);
    chk("addi_idle_waddr", waddr, 0);
    chk("addi_idle_alu_b", alu_b, 0);

    // Back-to-back RAW with valid held; instr changes while not ready
    set_reg(4'd1, 16'd5);
    set_reg(4'd2, 16'd7);
    got_q.delete();
    instr_valid = 1'b1; instr = 16'h0312;
    wait_ready();
    @(negedge clk);
    instr = 16'h0433;
    wait_ready();
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("b2b_first_addr", got_q[0].a, 3);
      chk("b2b_first_data", got_q[0].d, 16'd12);
      chk("b2b_second_addr", got_q[1].a, 4);
      chk("b2b_second_data", got_q[1].d, 16'd24);
      chk("b2b_spacing", got_q[1].c - got_q[0].c, 3);
    end
    chk("b2b_zero_flag", zero_flag, 0);

    // Illegal opcode from IDLE: one pulse, no write, flag preserved
    run_vec(vecs[1]);
    ill0 = ill_cnt;
    got_q.delete();
    issue(16'h9123);
    chk("ill_pulse", illegal, 1);
    chk("ill_ready", instr_ready, 1);
    @(negedge clk);
    chk("ill_pulse_end", illegal, 0);
    repeat (3) @(negedge clk);
    chk("ill_count", ill_cnt - ill0, 1);
    chk("ill_no_write", got_q.size(), 0);
    chk("ill_zero_flag", zero_flag, 1);

    // Asynchronous reset during EX
    set_reg(4'd1, 16'd5);
    set_reg(4'd2, 16'd7);
    got_q.delete();
    issue(16'h0312);
    @(negedge clk);
    chk("arst_pre_alu_a", alu_a, 16'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", instr_ready, 0);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_alu_b", alu_b, 0);
    chk("arst_raddr1", raddr1, 0);
    chk("arst_zero_flag", zero_flag, 0);
    repeat (3) @(negedge clk);
    chk("arst_no_write", got_q.size(), 0);
    rst_n = 1'b1;
    #1 chk("arst_ready_release", instr_ready, 1);
    @(negedge clk);
    run_vec(vecs[0]);

    // Illegal opcode offered during WB: write completes, pulse, back to IDLE
    ill0 = ill_cnt;
    got_q.delete();
    instr_valid = 1'b1; instr = 16'h0312;
    wait_ready();
    @(negedge clk);
    instr = 16'hA000;
    wait_ready();
    @(negedge clk);
    instr_valid = 1'b0;
    chk("illwb_pulse", illegal, 1);
    chk("illwb_write", got_q.size(), 1);
    @(negedge clk);
    chk("illwb_idle_ready", instr_ready, 1);
    chk("illwb_idle_raddr", raddr1, 0);
    chk("illwb_count", ill_cnt - ill0, 1);

    // Random stream against the instruction-level model
    for (int i = 1; i < 16; i++) set_reg(4'(i), 16'($urandom));
    got_q.delete();
    exp_q.delete();
    exp_ill = 0;
    ill0 = ill_cnt;
    zf_exp = 1'b0;
    for (int i = 0; i < 60; i++) begin
      opc = $urandom_range(0, 9);
      if (i == 0) opc = 0;
      if (opc >= 7) opc = $urandom_range(7, 15);
      if ($urandom_range(0, 4) == 0) opc = 5;
      rd = 4'($urandom); rs = 4'($urandom); rt = 4'($urandom);
      if (opc < 7) begin
        x = longint'(mregs[rs]);
        if (opc == 6) y = (rt >= 4'd8) ? longint'(rt) - 16 : longint'(rt);
        else          y = longint'(mregs[rt]);
        res = ref_exec(opc, x, y);
        zf_exp = (res == 16'd0);
        if (rd != 4'd0) begin
          exp_q.push_back('{a: rd, d: res, c: 0});
          mregs[rd] = res;
        end
      end else begin
        exp_ill++;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue({4'(opc), rd, rs, rt});
    end
    repeat (6) @(negedge clk);
    chk("rand_write_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rand_waddr_%0d", i), got_q[i].a, exp_q[i].a);
      chk($sformatf("rand_wdata_%0d", i), got_q[i].d, exp_q[i].d);
    end
    chk("rand_illegal_count", ill_cnt - ill0, exp_ill);
    chk("rand_zero_flag", zero_flag, zf_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
